// File: rtl/cfg_delay_line_pkg.sv
// Shared types and defaults for the configurable complex delay line.
package cfg_delay_line_pkg;

    localparam int R_W           = 16;
    localparam int N_MAX_DEFAULT = 512;

    typedef logic signed [R_W-1:0] r_t;

    typedef struct packed {
        r_t re;
        r_t im;
    } cplx_t;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } dl_state_t;

endpackage

// File: rtl/cfg_delay_ram.sv
// 1R1W sample RAM: synchronous write, combinational read, so a read and a
// write to the same address in one cycle return the old contents.
module cfg_delay_ram #(
    parameter int DW    = 32,
    parameter int DEPTH = 512,
    parameter int AW    = 9
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/cfg_delay_line.sv
// Runtime-configurable complex delay line with fill tracking.
// Optional product r*conj(r_dN) is built when CFG_DELAY_PROD_EN is defined.
module cfg_delay_line
    import cfg_delay_line_pkg::*;
#(
    parameter int W     = R_W,
    parameter int N_MAX = N_MAX_DEFAULT,
    parameter int AW    = $clog2(N_MAX)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_load,
    input  logic [AW:0]   cfg_delay,
    input  logic          in_valid,
    input  logic [W-1:0]  rx_re_in,
    input  logic [W-1:0]  rx_img_in,
    output logic          out_valid,
    output logic [W-1:0]  r_real,
    output logic [W-1:0]  r_imag,
    output logic [W-1:0]  r_dN_real,
    output logic [W-1:0]  r_dN_imag,
    output logic          dN_valid,
    output logic [AW:0]   fill_cnt,
    output logic [AW:0]   cur_delay
`ifdef CFG_DELAY_PROD_EN
    ,
    output logic [2*W:0]  prod_re,
    output logic [2*W:0]  prod_im,
    output logic          prod_valid
`endif
);

    localparam int          AW1   = AW + 1;
    localparam logic [AW:0] D_MAX = AW1'(N_MAX);

    dl_state_t     state;
    logic [AW-1:0] wr_ptr;

    logic [AW:0]   d_new, d_eff, d_last, fill_eff, fill_inc;
    logic [AW-1:0] ptr_eff;
    logic          run_eff;
    logic [2*W-1:0] rd_data;

    always_comb begin
        d_new = cfg_delay;
        if (cfg_delay == '0) begin
            d_new = AW1'(1);
        end else if (cfg_delay > D_MAX) begin
            d_new = D_MAX;
        end
    end

    // A load in the same cycle as a sample restarts the stream before that
    // sample is stored, so it becomes sample 0 of the new configuration.
    assign d_eff    = cfg_load ? d_new : cur_delay;
    assign ptr_eff  = cfg_load ? '0 : wr_ptr;
    assign fill_eff = cfg_load ? '0 : fill_cnt;
    assign run_eff  = !cfg_load && (state == ST_RUN);
    assign d_last   = d_eff - 1'b1;
    assign fill_inc = fill_eff + 1'b1;

    cfg_delay_ram #(
        .DW    (2*W),
        .DEPTH (N_MAX),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (in_valid && !rst),
        .addr  (ptr_eff),
        .wdata ({rx_re_in, rx_img_in}),
        .rdata (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_FILL;
            wr_ptr    <= '0;
            fill_cnt  <= '0;
            cur_delay <= D_MAX;
            out_valid <= 1'b0;
            dN_valid  <= 1'b0;
            r_real    <= '0;
            r_imag    <= '0;
            r_dN_real <= '0;
            r_dN_imag <= '0;
        end else begin
            if (cfg_load) begin
                cur_delay <= d_new;
                wr_ptr    <= '0;
                fill_cnt  <= '0;
                state     <= ST_FILL;
            end
            if (in_valid) begin
                wr_ptr    <= ({1'b0, ptr_eff} == d_last) ? '0 : ptr_eff + 1'b1;
                if (fill_eff != d_eff) begin
                    fill_cnt <= fill_inc;
                    state    <= (fill_inc == d_eff) ? ST_RUN : ST_FILL;
                end
                out_valid <= 1'b1;
                dN_valid  <= run_eff;
                r_real    <= rx_re_in;
                r_imag    <= rx_img_in;
                r_dN_real <= run_eff ? rd_data[2*W-1:W] : '0;
                r_dN_imag <= run_eff ? rd_data[W-1:0]   : '0;
            end else begin
                out_valid <= 1'b0;
                dN_valid  <= 1'b0;
            end
        end
    end

`ifdef CFG_DELAY_PROD_EN
    localparam int PW = 2*W + 1;

    function automatic logic signed [PW-1:0] sx(input logic [W-1:0] v);
        return PW'($signed(v));
    endfunction

    // r * conj(r_dN): re = a*c + b*d, im = b*c - a*d
    always_ff @(posedge clk) begin
        if (rst) begin
            prod_re    <= '0;
            prod_im    <= '0;
            prod_valid <= 1'b0;
        end else begin
            prod_re    <= sx(r_real) * sx(r_dN_real) + sx(r_imag) * sx(r_dN_imag);
            prod_im    <= sx(r_imag) * sx(r_dN_real) - sx(r_real) * sx(r_dN_imag);
            prod_valid <= dN_valid;
        end
    end
`endif

endmodule

// File: tb/tb_cfg_delay_line.sv
// Randomized bench for cfg_delay_line against a queue-based reference model.
module tb_cfg_delay_line;

    localparam int W     = 16;
    localparam int N_MAX = 512;
    localparam int AW    = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cfg_load = 1'b0;
    logic [AW:0]   cfg_delay = '0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  rx_re_in = '0;
    logic [W-1:0]  rx_img_in = '0;
    logic          out_valid, dN_valid;
    logic [W-1:0]  r_real, r_imag, r_dN_real, r_dN_imag;
    logic [AW:0]   fill_cnt, cur_delay;
`ifdef CFG_DELAY_PROD_EN
    logic [2*W:0]  prod_re, prod_im;
    logic          prod_valid;
`endif

    cfg_delay_line #(.W(W), .N_MAX(N_MAX)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_load  (cfg_load),
        .cfg_delay (cfg_delay),
        .in_valid  (in_valid),
        .rx_re_in  (rx_re_in),
        .rx_img_in (rx_img_in),
        .out_valid (out_valid),
        .r_real    (r_real),
        .r_imag    (r_imag),
        .r_dN_real (r_dN_real),
        .r_dN_imag (r_dN_imag),
        .dN_valid  (dN_valid),
        .fill_cnt  (fill_cnt),
        .cur_delay (cur_delay)
`ifdef CFG_DELAY_PROD_EN
        ,
        .prod_re   (prod_re),
        .prod_im   (prod_im),
        .prod_valid(prod_valid)
`endif
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: exp_q holds the samples accepted since the last
    // restart, trimmed to the newest D; its front is the sample D back.
    logic [2*W-1:0]       exp_q[$];
    int                   m_d = N_MAX;
    logic                 m_ov = 0, m_dv = 0;
    logic signed [W-1:0]  m_re = 0, m_im = 0, m_dre = 0, m_dim = 0;
    longint               m_pre = 0, m_pim = 0;
    logic                 m_pv = 0;

    task automatic check_outputs();
        check_eq("out_valid", out_valid, m_ov);
        check_eq("dN_valid",  dN_valid,  m_dv);
        check_eq("r_real",    $signed(r_real),    m_re);
        check_eq("r_imag",    $signed(r_imag),    m_im);
        check_eq("r_dN_real", $signed(r_dN_real), m_dre);
        check_eq("r_dN_imag", $signed(r_dN_imag), m_dim);
        check_eq("fill_cnt",  fill_cnt,  exp_q.size());
        check_eq("cur_delay", cur_delay, m_d);
`ifdef CFG_DELAY_PROD_EN
        check_eq("prod_re",    $signed(prod_re), m_pre);
        check_eq("prod_im",    $signed(prod_im), m_pim);
        check_eq("prod_valid", prod_valid,       m_pv);
`endif
    endtask

    // driver: one clock cycle with optional sample and optional load
    task automatic drive(input logic v, input logic [W-1:0] re, input logic [W-1:0] im,
                         input logic ld, input int dly);
        logic [2*W-1:0] s;
        m_pre = longint'(m_re) * m_dre + longint'(m_im) * m_dim;
        m_pim = longint'(m_im) * m_dre - longint'(m_re) * m_dim;
        m_pv  = m_dv;
        if (ld) begin
            m_d = (dly == 0) ? 1 : ((dly > N_MAX) ? N_MAX : dly);
            exp_q.delete();
        end
        if (v) begin
            m_ov = 1;
            m_dv = (exp_q.size() == m_d);
            if (m_dv) begin
                s = exp_q.pop_front();
                m_dre = s[2*W-1:W];
                m_dim = s[W-1:0];
            end else begin
                m_dre = 0;
                m_dim = 0;
            end
            exp_q.push_back({re, im});
            m_re = re;
            m_im = im;
        end else begin
            m_ov = 0;
            m_dv = 0;
        end
        in_valid  = v;
        rx_re_in  = re;
        rx_img_in = im;
        cfg_load  = ld;
        cfg_delay = (AW+1)'(dly);
        @(posedge clk);
        #1;
        check_outputs();
        in_valid = 0;
        cfg_load = 0;
    endtask

    task automatic do_reset();
        rst       = 1;
        in_valid  = 1'($urandom_range(0, 1));
        rx_re_in  = W'($urandom);
        rx_img_in = W'($urandom);
        @(posedge clk);
        #1;
        exp_q.delete();
        m_d = N_MAX; m_ov = 0; m_dv = 0;
        m_re = 0; m_im = 0; m_dre = 0; m_dim = 0;
        m_pre = 0; m_pim = 0; m_pv = 0;
        check_outputs();
        rst = 0;
        in_valid = 0;
    endtask

    task automatic ramp(input int n);
        for (int k = 0; k < n; k++) begin
            drive(1'b1, W'(k), W'(-k), 1'b0, 0);
        end
    endtask

    initial begin
        do_reset();

        // default delay ramp
        ramp(600);

        // runtime delay 16, then 3 mid-stream
        drive(1'b0, '0, '0, 1'b1, 16);
        ramp(40);
        drive(1'b0, '0, '0, 1'b1, 3);
        ramp(20);

        // clamping
        drive(1'b0, '0, '0, 1'b1, 0);
        check_eq("clamp_lo", cur_delay, 1);
        ramp(6);
        drive(1'b0, '0, '0, 1'b1, 1023);
        check_eq("clamp_hi", cur_delay, N_MAX);

        // gaps at 50% density with D=8
        drive(1'b0, '0, '0, 1'b1, 8);
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), W'($urandom), W'($urandom), 1'b0, 0);
        end

        // load colliding with a sample
        drive(1'b1, W'($urandom), W'($urandom), 1'b1, 5);
        check_eq("collide_fill", fill_cnt, 1);
        for (int i = 0; i < 200; i++) begin
            drive(1'($urandom_range(0, 3) != 0), W'($urandom), W'($urandom),
                  1'($urandom_range(0, 24) == 0), $urandom_range(0, 20));
        end

        // reset mid-RUN
        drive(1'b1, W'($urandom), W'($urandom), 1'b1, 2);
        ramp(6);
        do_reset();
        check_eq("rst_fill", fill_cnt, 0);
        ramp(3);

`ifdef CFG_DELAY_PROD_EN
        drive(1'b1, W'(1), W'(-2), 1'b1, 4);
        for (int i = 0; i < 3; i++) drive(1'b1, '0, '0, 1'b0, 0);
        drive(1'b1, W'(3), W'(4), 1'b0, 0);
        check_eq("dir_dN_valid", dN_valid, 1);
        drive(1'b0, '0, '0, 1'b0, 0);
        check_eq("dir_prod_re", $signed(prod_re), -5);
        check_eq("dir_prod_im", $signed(prod_im), 10);
        check_eq("dir_prod_valid", prod_valid, 1);
        drive(1'b0, '0, '0, 1'b0, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
